// File: rtl/aes_round_tail.sv
// AES round tail: ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey,
// wrapped in valid/ready handshakes. Define AES_ROUND_TAIL_PARALLEL_EN for the four-column single-cycle build.
module aes_round_tail (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nx;
    logic [127:0] sreg, kreg, oreg;
    logic         lreg;
`ifndef AES_ROUND_TAIL_PARALLEL_EN
    logic [1:0]   col;
`endif

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One output column c: ShiftRows source select, MixColumns, AddRoundKey.
    function automatic logic [31:0] col_fn(input logic [127:0] s, input logic [127:0] k,
                                           input logic last, input logic [1:0] c);
        logic [7:0] t [4];
        logic [7:0] m [4];
        logic [7:0] o [4];
        logic [1:0] src;
        for (int unsigned r = 0; r < 4; r++) begin
            src  = c + 2'(r);
            t[r] = s[127 - 8*(4*int'(src) + int'(r)) -: 8];
        end
        m[0] = xt(t[0]) ^ xt(t[1]) ^ t[1] ^ t[2] ^ t[3];
        m[1] = t[0] ^ xt(t[1]) ^ xt(t[2]) ^ t[2] ^ t[3];
        m[2] = t[0] ^ t[1] ^ xt(t[2]) ^ xt(t[3]) ^ t[3];
        m[3] = xt(t[0]) ^ t[0] ^ t[1] ^ t[2] ^ xt(t[3]);
        for (int unsigned r = 0; r < 4; r++) begin
            o[r] = (last ? t[r] : m[r]) ^ k[127 - 8*(4*int'(c) + int'(r)) -: 8];
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
`ifdef AES_ROUND_TAIL_PARALLEL_EN
                state_nx = DONE;
`else
                if (col == 2'd3) state_nx = DONE;
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            kreg <= '0;
            lreg <= 1'b0;
            oreg <= '0;
`ifndef AES_ROUND_TAIL_PARALLEL_EN
            col  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sreg <= in_data;
                    kreg <= round_key;
                    lreg <= last_round;
`ifndef AES_ROUND_TAIL_PARALLEL_EN
                    col  <= '0;
`endif
                end
                BUSY: begin
`ifdef AES_ROUND_TAIL_PARALLEL_EN
                    for (int unsigned c = 0; c < 4; c++)
                        oreg[127 - 32*c -: 32] <= col_fn(sreg, kreg, lreg, 2'(c));
`else
                    oreg[127 - 32*int'(col) -: 32] <= col_fn(sreg, kreg, lreg, col);
                    if (col != 2'd3) col <= col + 2'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign out_data = oreg;

endmodule

// File: tb/tb_aes_round_tail.sv
// Self-checking bench for aes_round_tail: FIPS-197 vectors, random states against a
// byte-matrix reference model, backpressure and mid-operation reset.
module tb_aes_round_tail;

`ifdef AES_ROUND_TAIL_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    aes_round_tail dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    typedef struct {
        logic [127:0] din;
        logic [127:0] key;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    // Generic GF(2^8) multiply by shift-and-add with 0x11B reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] din, input logic [127:0] key,
                                           input logic last);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] m [4][4];
        logic [7:0] coef [4];
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int b = 0; b < 16; b++) s[b % 4][b / 4] = din[127 - 8*b -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                m[r][c] = 8'h00;
                for (int i = 0; i < 4; i++) m[r][c] = m[r][c] ^ gmul(coef[(i - r + 4) % 4], t[i][c]);
                if (last) m[r][c] = t[r][c];
            end
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = m[b % 4][b / 4] ^ key[127 - 8*b -: 8];
        return res;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Accept one state, check latency/result/handshake flags, then complete the handshake.
    task automatic run(input string nm, input logic [127:0] din, input logic [127:0] key,
                       input logic last, input logic [127:0] exp, input int hold);
        int n;
        logic [127:0] snap;
        @(negedge clk);
        chk({nm, " in_ready before accept"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1; in_data = din; round_key = key; last_round = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        round_key = {$urandom, $urandom, $urandom, $urandom};
        last_round = ~last;
        n = 0;
        while (!out_valid && n < 20) begin
            chk({nm, " in_ready busy"}, 128'(in_ready), 128'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 128'(n), 128'(LAT));
        chk({nm, " data"}, out_data, exp);
        chk({nm, " in_ready while out_valid"}, 128'(in_ready), 128'd0);
        snap = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk({nm, " hold data"}, out_data, snap);
            chk({nm, " hold valid"}, 128'(out_valid), 128'd1);
            chk({nm, " hold in_ready"}, 128'(in_ready), 128'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " idle after handshake"}, {127'd0, in_ready}, 128'd1);
        chk({nm, " valid drop"}, 128'(out_valid), 128'd0);
    endtask

    vec_t vecs [6];

    initial begin
        logic [127:0] d, k;
        logic l;
        vecs[0] = '{128'hdb000000_00130000_00005300_00000045, 128'h0, 1'b0,
                    128'h8e4da1bc_00000000_00000000_00000000};
        vecs[1] = '{128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                    1'b0, 128'ha49c7ff2_689f352b_6b5bea43_026a5049};
        vecs[2] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b1,
                    128'h00050a0f_04090e03_080d0207_0c01060b};
        vecs[3] = '{128'h0, 128'h0123456789abcdef_fedcba9876543210, 1'b0, 128'h0123456789abcdef_fedcba9876543210};
        vecs[4] = '{128'h0, 128'hdeadbeef_cafef00d_01020304_a5a5a5a5, 1'b1, 128'hdeadbeef_cafef00d_01020304_a5a5a5a5};
        vecs[5] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'h0, 1'b0, 128'hffffffff_ffffffff_ffffffff_ffffffff};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; round_key = '0; last_round = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(in_ready), 128'd1);
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset out_data", out_data, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), vecs[i].din, vecs[i].key, vecs[i].last, vecs[i].exp, 0);

        run("backpressure", vecs[1].din, vecs[1].key, 1'b0, vecs[1].exp, 10);

        for (int i = 0; i < 20; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            l = 1'($urandom_range(0, 3) == 0);
            run($sformatf("rand%0d", i), d, k, l, model(d, k, l), int'($urandom_range(0, 2)));
        end

        // Reset two edges after accept: mid-column in the serial build, discarding the result.
        @(negedge clk);
        in_valid = 1'b1; in_data = vecs[1].din; round_key = vecs[1].key; last_round = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("rst in_ready", 128'(in_ready), 128'd1);
        chk("rst out_valid", 128'(out_valid), 128'd0);
        chk("rst out_data", out_data, 128'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rst no accept", 128'(in_ready), 128'd1);
            chk("rst no valid", 128'(out_valid), 128'd0);
        end
        run("post-reset", vecs[1].din, vecs[1].key, 1'b0, vecs[1].exp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_round_tail.md
# aes_round_tail

Sequential AES encryption round-tail stage that sits directly downstream of the 16-byte SubBytes S-box lookup. It consumes one substituted 128-bit state and applies ShiftRows, then MixColumns, then AddRoundKey. MixColumns is skipped when the final-round flag is set. MixColumns is computed column-serially (one 32-bit column per cycle) to share a single column multiplier, and the block is wrapped in valid/ready handshakes on both sides.

## Interface
- No parameters.
- `clk` — input, 1 — sole clock; all state updates on the rising edge.
- `rst` — input, 1 — synchronous, active-high reset.
- `in_valid` — input, 1 — `in_data`, `round_key` and `last_round` are valid.
- `in_ready` — output, 1 — block can accept a state.
- `in_data` — input, 128 — SubBytes output state.
- `round_key` — input, 128 — round key for AddRoundKey.
- `last_round` — input, 1 — final round; skip MixColumns.
- `out_valid` — output, 1 — `out_data` holds a completed round result.
- `out_ready` — input, 1 — consumer accepts `out_data`.
- `out_data` — output, 128 — round result.

Byte order, used on every 128-bit bus:
- Byte b is bits [127-8b : 120-8b], so byte 0 is the MSB.
- Byte b is state element s(r,c) with r = b mod 4 and c = b / 4 (column-major, FIPS-197 order).

## Operation
FSM states:
- **IDLE:** `in_ready`=1. When `in_valid`&&`in_ready`, register `in_data`, `round_key` and `last_round`, clear the column counter, and go to BUSY.
- **BUSY:** `in_ready`=0. On each edge, process column `col` (2-bit counter 0..3) and write it into the output register. At `col`=3, go to DONE; otherwise increment `col`.
- **DONE:** `out_valid`=1 and `out_data` holds stable. When `out_ready`=1, go to IDLE. While `out_ready`=0, hold indefinitely.

Per-column datapath:
- **ShiftRows:** t(r,c) = s(r,(c+r) mod 4), taken from the registered input.
- **MixColumns:** applied to column c of t using GF(2^8) with polynomial 0x11B. xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
  - m0 = 2t0^3t1^t2^t3
  - m1 = t0^2t1^3t2^t3
  - m2 = t0^t1^2t2^3t3
  - m3 = 3t0^t1^t2^2t3
  - 3x = xtime(x)^x.
- **Final round:** if the registered `last_round`=1, m = t.
- **AddRoundKey:** out(r,c) = m(r,c) ^ key(r,c), from the registered key.

Input handling:
- Inputs are sampled only on the accept edge. Later changes to `in_data`, `round_key` or `last_round` have no effect on the block in flight.
- No overlap: a new state is accepted only in IDLE.

## Timing
- **Reset:** state=IDLE, `col`=0, `in_ready`=1 (combinational from IDLE), `out_valid`=0, `out_data`=128'h0, and all internal registers are zeroed.
- **Latency:** accept at edge k. BUSY edges are k+1..k+4. `out_valid` is high after edge k+4.
- **Throughput:** output accepted at edge k+5 (with `out_ready` held high) returns to IDLE. The next accept is possible at edge k+6, i.e. one state per 6 cycles.
- `in_ready` and `out_valid` are never both 1.
- `rst` asserted in any state:
  - next edge forces the reset values;
  - a partially computed result is discarded and `out_valid` never rises for it.
- `rst` wins over simultaneous `in_valid` or `out_ready`.
- `out_valid`, once high, stays high with `out_data` unchanged until handshake or reset.

## Configuration
- **`AES_ROUND_TAIL_PARALLEL_EN` defined:**
  - four column units are instantiated and all columns are computed in a single BUSY edge;
  - latency is 1 BUSY cycle, so `out_valid` rises after edge k+1, and throughput is one state per 3 cycles;
  - `col` is unused and held at 0.
- **Undefined (default):** the column-serial 4-cycle behaviour above.
- Results are bit-identical in both builds.

## Test plan
- **MixColumns vector:** `in_data` with column 0 = db 13 53 45 after ShiftRows (all rows of that column sourced accordingly), other columns 0, key=0, `last_round`=0. Required: output column 0 = 8e 4d a1 bc.
- **FIPS-197 Appendix B round 1:** `in_data`=d427 11ae e0bf 98f1 b8b4 5de5 1e41 5230, `round_key`=a0fa fe17 8854 2cb1 23a3 3939 2a6c 7605, `last_round`=0. Required: `out_data`=a49c 7ff2 689f 352b 6b5b ea43 026a 5049, with `out_valid` high after edge k+4 (k+1 in the parallel build).
- **Final round, ShiftRows only:** `in_data`=0001…0f, key=0, `last_round`=1. Required: `out_data`=00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` rises, and toggle `in_data`/`in_valid` throughout. Required: `out_data` is stable, `in_ready`=0, and there is no second accept until one cycle after the handshake.
- **Key-only path:** `in_data`=0, any key K, either `last_round` value. Required: `out_data`=K.
- **Reset mid-operation:** assert `rst` for 1 cycle at BUSY `col`=2. Required: next cycle `in_ready`=1, `out_valid`=0, `out_data`=0. A fresh state accepted afterwards produces the correct result.
